// File: rtl/rx_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo_if
// Bundles the receive-side write beats, the read handshake and the frame
// statistics of rx_frame_fifo. Signal names match the block's original
// port list.
//   slave  : the FIFO itself (consumes write beats, produces read data)
//   master : the environment (upstream receiver plus downstream consumer)
// Signals:
//   data_in[7:0], data_in_enable, data_in_start, data_in_end, data_in_error
//                 : write beat from the upstream receive stage
//   fifo_full     : no free entry for the next beat
//   rd_data[7:0], rd_valid, rd_last, rd_ready
//                 : first-word-fall-through read port
//   frames_ok[15:0], frames_dropped[15:0] : frame counters
// ---------------------------------------------------------------------------
interface rx_frame_fifo_if;
    logic [7:0]  data_in;
    logic        data_in_enable;
    logic        data_in_start;
    logic        data_in_end;
    logic        data_in_error;
    logic        fifo_full;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_ready;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    modport slave (
        input  data_in, data_in_enable, data_in_start, data_in_end, data_in_error,
        input  rd_ready,
        output fifo_full, rd_data, rd_valid, rd_last, frames_ok, frames_dropped
    );

    modport master (
        output data_in, data_in_enable, data_in_start, data_in_end, data_in_error,
        output rd_ready,
        input  fifo_full, rd_data, rd_valid, rd_last, frames_ok, frames_dropped
    );
endinterface

// File: rtl/rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo
// Frame-aware receive buffer. Bytes of a frame are written speculatively and
// only become visible to the reader once the frame ends without error. Bad,
// abandoned or overflowing frames are rolled back by restoring the write
// pointer to the frame start.
// Ports:
//   clock  : single clock, all state on its rising edge
//   reset  : asynchronous, active-high
//   bus    : rx_frame_fifo_if.slave (write beats, read handshake, counters)
// Parameters:
//   ADDR_WIDTH : buffer holds 2**ADDR_WIDTH entries of {last, data[7:0]}
// Configuration macro:
//   RX_FRAME_FIFO_STATS_EN : when defined, frames_ok / frames_dropped are
//                            saturating counters; otherwise both read 0.
// ---------------------------------------------------------------------------
module rx_frame_fifo #(
    parameter int ADDR_WIDTH = 11
) (
    input logic         clock,
    input logic         reset,
    rx_frame_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WRITE    = 2'd1;
    localparam logic [1:0] S_OVERFLOW = 2'd2;

    logic [8:0]            r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_commit_ptr;
    logic [ADDR_WIDTH:0]   r_frame_base;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [1:0]            r_state;
    logic [7:0]            r_rd_data;
    logic                  r_rd_last;
    logic                  r_rd_valid;

    logic [ADDR_WIDTH:0]   w_wr_nxt;
    logic [ADDR_WIDTH:0]   w_commit_nxt;
    logic [ADDR_WIDTH:0]   w_base_nxt;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH:0]   w_p;
    logic [ADDR_WIDTH:0]   w_b;
    logic                  w_beat;
    logic                  w_p_full;
    logic                  w_we;
    logic                  w_ok_inc;
    logic [1:0]            w_drop_inc;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_load;

    // Full when the two pointers address the same slot on different laps.
    function automatic logic ptr_full(input logic [ADDR_WIDTH:0] wp,
                                      input logic [ADDR_WIDTH:0] rp);
        return (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]) &&
               (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]);
    endfunction

    assign w_full  = ptr_full(r_wr_ptr, r_rd_ptr);
    assign w_empty = (r_rd_ptr == r_commit_ptr);
    assign w_load  = (!r_rd_valid || bus.rd_ready) && !w_empty;

    // Write FSM. A beat that stores a byte is handled by one common path:
    // w_p is the slot it goes to and w_b the start of its frame. A start
    // seen in WRITE rewinds w_p to the old frame base, so the new frame
    // reuses the abandoned space.
    always_comb begin
        w_wr_nxt     = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_base_nxt   = r_frame_base;
        w_state_nxt  = r_state;
        w_we         = 1'b0;
        w_ok_inc     = 1'b0;
        w_drop_inc   = 2'd0;
        w_beat       = 1'b0;
        w_p          = r_wr_ptr;
        w_b          = r_frame_base;

        if (bus.data_in_enable) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.data_in_start) begin
                        w_beat = 1'b1;
                        w_b    = r_wr_ptr;
                    end
                end
                S_WRITE: begin
                    w_beat = 1'b1;
                    if (bus.data_in_start) begin
                        w_drop_inc = 2'd1;
                        w_p        = r_frame_base;
                    end
                end
                S_OVERFLOW: begin
                    if (bus.data_in_end) begin
                        w_wr_nxt    = r_frame_base;
                        w_drop_inc  = 2'd1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_p_full = ptr_full(w_p, r_rd_ptr);

        if (w_beat) begin
            w_base_nxt = w_b;
            if (w_p_full) begin
                if (bus.data_in_end) begin
                    w_wr_nxt    = w_b;
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wr_nxt    = w_p;
                    w_state_nxt = S_OVERFLOW;
                end
            end else begin
                w_we = 1'b1;
                if (bus.data_in_end && !bus.data_in_error) begin
                    w_wr_nxt     = w_p + PTR_ONE;
                    w_commit_nxt = w_p + PTR_ONE;
                    w_ok_inc     = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (bus.data_in_end) begin
                    w_wr_nxt    = w_b;
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wr_nxt    = w_p + PTR_ONE;
                    w_state_nxt = S_WRITE;
                end
            end
        end
    end

    // Storage is not reset; only committed slots are ever read.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_p[ADDR_WIDTH-1:0]] <= {bus.data_in_end, bus.data_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_frame_base <= '0;
            r_state      <= S_IDLE;
        end else begin
            r_wr_ptr     <= w_wr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_frame_base <= w_base_nxt;
            r_state      <= w_state_nxt;
        end
    end

    // Registered FWFT output stage; rd_ptr advances when a slot is moved
    // into the stage, so the stage adds one entry beyond the RAM depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else if (w_load) begin
            r_rd_data  <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]][7:0];
            r_rd_last  <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]][8];
            r_rd_valid <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        end else if (bus.rd_ready) begin
            r_rd_valid <= 1'b0;
        end
    end

    assign bus.fifo_full = w_full & ~reset;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_last   = r_rd_last;
    assign bus.rd_valid  = r_rd_valid;

`ifdef RX_FRAME_FIFO_STATS_EN
    logic [15:0] r_frames_ok;
    logic [15:0] r_frames_dropped;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_frames_dropped} + {15'd0, w_drop_inc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frames_ok      <= '0;
            r_frames_dropped <= '0;
        end else begin
            if (w_ok_inc && (r_frames_ok != '1)) begin
                r_frames_ok <= r_frames_ok + 16'd1;
            end
            r_frames_dropped <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
        end
    end

    assign bus.frames_ok      = r_frames_ok;
    assign bus.frames_dropped = r_frames_dropped;
`else
    logic w_unused_stats;
    assign w_unused_stats     = ^{w_ok_inc, w_drop_inc};
    assign bus.frames_ok      = '0;
    assign bus.frames_dropped = '0;
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_fifo
// Directed bench for rx_frame_fifo: a default-size instance (u_big) and an
// ADDR_WIDTH=4 instance (u_small) share clock, reset and write data; sel
// routes the write enable to one of them. Read bytes are collected per
// instance and compared against hand-computed frame contents.
// ---------------------------------------------------------------------------
module tb_rx_frame_fifo;
`ifdef RX_FRAME_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int         len;
        logic [7:0] first;
        bit         err;
        int         exp_count;
        int         ok_inc;
        int         drop_inc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_data = '0;
    logic       d_en = 1'b0, d_start = 1'b0, d_end = 1'b0, d_err = 1'b0;
    logic       sel = 1'b0, rdy_b = 1'b1, rdy_s = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ok_b = 0, exp_drop_b = 0, exp_ok_s = 0, exp_drop_s = 0;
    logic [8:0] q_b[$];
    logic [8:0] q_s[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    rx_frame_fifo_if bus_b();
    rx_frame_fifo_if bus_s();

    assign bus_b.data_in        = d_data;
    assign bus_b.data_in_enable = d_en & ~sel;
    assign bus_b.data_in_start  = d_start;
    assign bus_b.data_in_end    = d_end;
    assign bus_b.data_in_error  = d_err;
    assign bus_b.rd_ready       = rdy_b;
    assign bus_s.data_in        = d_data;
    assign bus_s.data_in_enable = d_en & sel;
    assign bus_s.data_in_start  = d_start;
    assign bus_s.data_in_end    = d_end;
    assign bus_s.data_in_error  = d_err;
    assign bus_s.rd_ready       = rdy_s;

    rx_frame_fifo u_big (.clock(clk), .reset(rst), .bus(bus_b));
    rx_frame_fifo #(.ADDR_WIDTH(4)) u_small (.clock(clk), .reset(rst), .bus(bus_s));

    // Handshakes are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_b.rd_valid && bus_b.rd_ready) q_b.push_back({bus_b.rd_last, bus_b.rd_data});
            if (bus_s.rd_valid && bus_s.rd_ready) q_s.push_back({bus_s.rd_last, bus_s.rd_data});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    function automatic logic [31:0] cexp(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ok_b"},   32'(bus_b.frames_ok),      cexp(exp_ok_b));
        check({tag, "_drop_b"}, 32'(bus_b.frames_dropped), cexp(exp_drop_b));
        check({tag, "_ok_s"},   32'(bus_s.frames_ok),      cexp(exp_ok_s));
        check({tag, "_drop_s"}, 32'(bus_s.frames_dropped), cexp(exp_drop_s));
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic er);
        d_data = d; d_en = 1'b1; d_start = s; d_end = e; d_err = er;
        @(posedge clk); #1;
        d_en = 1'b0; d_start = 1'b0; d_end = 1'b0; d_err = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] first, input bit err);
        for (int i = 0; i < len; i++)
            beat(first + 8'(i), i == 0, i == len - 1, err && (i == len - 1));
    endtask

    // Compares the collected bytes of one instance with consecutive frames of
    // flen bytes starting at value first; rd_last expected on each frame end.
    task automatic check_q(input bit s, input string name, input logic [7:0] first,
                           input int total, input int flen);
        logic [8:0] q[$];
        logic [8:0] e;
        if (s) begin q = q_s; q_s.delete(); end
        else begin q = q_b; q_b.delete(); end
        check({name, "_count"}, 32'(q.size()), 32'(total));
        for (int i = 0; i < total && i < q.size(); i++) begin
            e = {((i + 1) % flen) == 0, first + 8'(i)};
            check($sformatf("%s_byte%0d", name, i), 32'(q[i]), 32'(e));
        end
    endtask

    initial begin
        vecs[0] = '{64, 8'h00, 1'b0, 64, 1, 0};
        vecs[1] = '{64, 8'h00, 1'b1,  0, 0, 1};
        vecs[2] = '{ 1, 8'hA5, 1'b0,  1, 1, 0};
        vecs[3] = '{ 5, 8'h80, 1'b1,  0, 0, 1};
        vecs[4] = '{ 3, 8'h10, 1'b0,  3, 1, 0};
        vecs[5] = '{ 2, 8'hFE, 1'b0,  2, 1, 0};

        // Reset state
        #3;
        check("rst_valid", 32'(bus_b.rd_valid), 32'd0);
        check("rst_data",  32'(bus_b.rd_data),  32'd0);
        check("rst_last",  32'(bus_b.rd_last),  32'd0);
        check("rst_full_b", 32'(bus_b.fifo_full), 32'd0);
        check("rst_full_s", 32'(bus_s.fifo_full), 32'd0);
        check_counters("rst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Table: whole frames into the big instance with the reader always ready
        for (int i = 0; i < 6; i++) begin
            sel = 1'b0; rdy_b = 1'b1;
            send_frame(vecs[i].len, vecs[i].first, vecs[i].err);
            repeat (vecs[i].len + 10) @(posedge clk);
            #1;
            exp_ok_b   += vecs[i].ok_inc;
            exp_drop_b += vecs[i].drop_inc;
            check_q(1'b0, $sformatf("vec%0d", i), vecs[i].first, vecs[i].exp_count, vecs[i].len);
            check_counters($sformatf("vec%0d", i));
        end

        // Commit latency and output hold while the reader stalls
        rdy_b = 1'b0;
        send_frame(3, 8'h21, 1'b0);
        check("commit_edge_valid", 32'(bus_b.rd_valid), 32'd0);
        @(posedge clk); #1;
        check("commit_next_valid", 32'(bus_b.rd_valid), 32'd1);
        check("commit_next_data",  32'(bus_b.rd_data),  32'h21);
        check("commit_next_last",  32'(bus_b.rd_last),  32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", k), 32'(bus_b.rd_valid), 32'd1);
            check($sformatf("hold%0d_data", k),  32'(bus_b.rd_data),  32'h21);
        end
        rdy_b = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_ok_b++;
        check_q(1'b0, "hold", 8'h21, 3, 3);
        check_counters("hold");

        // Start reasserted after 10 bytes, then a good 64-byte frame
        for (int i = 0; i < 10; i++) beat(8'hC0 + 8'(i), i == 0, 1'b0, 1'b0);
        send_frame(64, 8'h00, 1'b0);
        repeat (80) @(posedge clk);
        #1;
        exp_ok_b++; exp_drop_b++;
        check_q(1'b0, "restart", 8'h00, 64, 64);
        check_counters("restart");

        // Small instance: overflow of a 20-byte frame with the reader stalled
        sel = 1'b1; rdy_s = 1'b0;
        for (int i = 0; i < 15; i++) beat(8'h40 + 8'(i), i == 0, 1'b0, 1'b0);
        check("ovf_full_at_15", 32'(bus_s.fifo_full), 32'd0);
        beat(8'h4F, 1'b0, 1'b0, 1'b0);
        check("ovf_full_at_16", 32'(bus_s.fifo_full), 32'd1);
        for (int i = 16; i < 20; i++) beat(8'h40 + 8'(i), 1'b0, i == 19, 1'b0);
        check("ovf_full_after", 32'(bus_s.fifo_full), 32'd0);
        exp_drop_s++;
        rdy_s = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("ovf_empty%0d", k), 32'(bus_s.rd_valid), 32'd0);
        end
        check_q(1'b1, "ovf", 8'h00, 0, 1);
        check_counters("ovf");

        // Small instance: 3x12-byte frames across the pointer wrap, reader toggling
        fork
            begin
                for (int k = 0; k < 170; k++) begin
                    @(posedge clk); #1;
                    rdy_s = ~rdy_s;
                end
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    send_frame(12, 8'h60 + 8'(12 * f), 1'b0);
                    repeat (40) @(posedge clk);
                    #1;
                end
            end
        join
        rdy_s = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_ok_s += 3;
        check_q(1'b1, "wrap", 8'h60, 36, 12);
        check_counters("wrap");

        // Reset in the middle of frames on both instances
        sel = 1'b1; rdy_s = 1'b0;
        for (int i = 0; i < 16; i++) beat(8'h70 + 8'(i), i == 0, 1'b0, 1'b0);
        check("pre_rst_full_s", 32'(bus_s.fifo_full), 32'd1);
        sel = 1'b0; rdy_b = 1'b0;
        beat(8'hFF, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus_b.rd_valid), 32'd1);
        check("pre_rst_data",  32'(bus_b.rd_data),  32'hFF);
        check("pre_rst_last",  32'(bus_b.rd_last),  32'd1);
        for (int i = 0; i < 30; i++) beat(8'hB0 + 8'(i), i == 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid",  32'(bus_b.rd_valid),  32'd0);
        check("mid_rst_data",   32'(bus_b.rd_data),   32'd0);
        check("mid_rst_last",   32'(bus_b.rd_last),   32'd0);
        check("mid_rst_full_b", 32'(bus_b.fifo_full), 32'd0);
        check("mid_rst_full_s", 32'(bus_s.fifo_full), 32'd0);
        exp_ok_b = 0; exp_drop_b = 0; exp_ok_s = 0; exp_drop_s = 0;
        check_counters("mid_rst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        q_b.delete(); q_s.delete();
        rdy_b = 1'b1; rdy_s = 1'b1;
        send_frame(20, 8'h90, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        exp_ok_b = 1;
        check_q(1'b0, "post_rst", 8'h90, 20, 20);
        check_q(1'b1, "post_rst_small", 8'h00, 0, 1);
        check_counters("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rx_frame_fifo.md
RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 Parameter ADDR_WIDTH, default 11; buffer depth is 2**ADDR_WIDTH entries of 9 bits each (8-bit data plus a last flag).
REQ-002 Port clock, input, 1 bit; the single clock, with all state on its rising edge.
REQ-003 Port reset, input, 1 bit; asynchronous, active-high reset.
REQ-004 Port data_in, input, 8 bits; receive byte from the upstream receive stage.
REQ-005 Port data_in_enable, input, 1 bit; data_in is valid this cycle.
REQ-006 Port data_in_start, input, 1 bit; the current beat is the first byte of a frame.
REQ-007 Port data_in_end, input, 1 bit; the current beat is the last byte of a frame.
REQ-008 Port data_in_error, input, 1 bit; the frame ending this cycle is bad; only meaningful with data_in_end.
REQ-009 Port fifo_full, output, 1 bit; no free entry is available; this drives the upstream fifo_full.
REQ-010 Port rd_data, output, 8 bits; head byte.
REQ-011 Port rd_valid, output, 1 bit; rd_data holds a byte of a committed frame.
REQ-012 Port rd_last, output, 1 bit; rd_data is the last byte of its frame.
REQ-013 Port rd_ready, input, 1 bit; the consumer accepts the head byte when both rd_valid and rd_ready are high.
REQ-014 Port frames_ok, output, 16 bits; count of committed frames.
REQ-015 Port frames_dropped, output, 16 bits; count of discarded frames.

Function
REQ-016 The block SHALL keep four pointers, each ADDR_WIDTH+1 bits wide with an MSB wrap bit: wr_ptr, commit_ptr, frame_base and rd_ptr.
REQ-017 The write FSM SHALL have three states:
- IDLE: waiting for a frame start.
- WRITE: storing the bytes of a frame.
- OVERFLOW: discarding the rest of a frame that did not fit.
REQ-018 In IDLE, a beat with enable and start SHALL do the following:
- set frame_base to wr_ptr;
- write the byte;
- go to WRITE.
REQ-019 In IDLE, an enabled beat without start SHALL be ignored.
REQ-020 In WRITE, each enabled beat SHALL be written at wr_ptr, and wr_ptr SHALL increment; the last flag is written equal to data_in_end.
REQ-021 A beat with end and without error SHALL do the following:
- set commit_ptr to wr_ptr+1 on the same edge;
- increment frames_ok;
- go to IDLE.
REQ-022 A beat with end and error SHALL do the following:
- restore wr_ptr to frame_base;
- leave commit_ptr unchanged;
- increment frames_dropped;
- go to IDLE.
REQ-023 An enabled beat arriving while fifo_full is high SHALL NOT be written, and the FSM SHALL go to OVERFLOW.
REQ-024 If that beat also carries end, the frame SHALL be dropped immediately as in REQ-022 and the FSM SHALL go to IDLE instead.
REQ-025 In OVERFLOW, beats SHALL be discarded until a beat with end arrives; that beat restores wr_ptr to frame_base, increments frames_dropped and returns the FSM to IDLE, regardless of error.
REQ-026 A beat with start received in WRITE SHALL abandon the partial frame:
- restore wr_ptr to frame_base and increment frames_dropped;
- treat the beat as the first byte of a new frame, with the byte written at the restored pointer.
REQ-027 fifo_full SHALL be high whenever wr_ptr and rd_ptr differ only in the MSB; it is combinational from the registered pointers.
REQ-028 The read side SHALL see committed data only; the block is empty when rd_ptr equals commit_ptr.
REQ-029 The read output SHALL be a registered, first-word-fall-through stage:
- rd_data, rd_last and rd_valid load from RAM[rd_ptr] whenever the output is empty or a handshake occurs, and committed data exists;
- rd_ptr increments on each load.
REQ-030 When a frame commits at edge N, rd_valid SHALL be high after edge N+1 if the output stage was empty.
REQ-031 rd_valid, rd_data and rd_last SHALL be held stable while rd_valid is high and rd_ready is low.
REQ-032 A read and a write in the same cycle SHALL both take effect; wrap-around is handled by the MSB comparison, with no lost entry.
REQ-033 frames_ok and frames_dropped SHALL saturate at 16'hFFFF.

Reset
REQ-034 When reset is asserted, the block SHALL immediately and asynchronously do the following:
- clear all pointers;
- set the FSM to IDLE;
- drive rd_valid, rd_last, rd_data, frames_ok and frames_dropped to 0.
REQ-035 fifo_full SHALL be 0 while reset is asserted.
REQ-036 RAM contents SHALL NOT be reset.
REQ-037 Reset asserted during WRITE SHALL discard the partial frame and all committed frames, with no counter update.

Configuration
REQ-038 Macro RX_FRAME_FIFO_STATS_EN SHALL select the frame counters:
- defined: frames_ok and frames_dropped are implemented as specified.
- undefined: both ports remain present and are driven constant 0, with no counter registers.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- 64-byte frame 0x00..0x3F, end, no error -> 64 bytes read in order, rd_last only on 0x3F, frames_ok=1.
- 64-byte frame with data_in_error=1 on the end beat -> rd_valid never asserts, wr_ptr back to 0, frames_dropped=1.
- ADDR_WIDTH=4 with rd_ready=0, then a 20-byte frame -> fifo_full after 16 bytes, frame dropped, buffer empty.
- Start reasserted after 10 bytes, then a 64-byte good frame -> only the 64-byte frame is read, frames_dropped=1, frames_ok=1.
- rd_ready toggling 1/0 across a pointer wrap with ADDR_WIDTH=4 and 3x12-byte frames -> all 36 bytes in order, none duplicated.
- Reset mid-frame at byte 30 -> all outputs 0 immediately, and the next good frame is received intact.
